// File: rtl/vga_pkg.sv
// Shared constants and FSM state encoding for the VGA framebuffer arbiter.
package vga_pkg;
    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int PIX_W   = 12;
    localparam int ADDR_W  = 17;
    localparam int FB_SIZE = 76800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        LAT  = 2'd2
    } state_t;
endpackage

// File: rtl/vga_fb_arbiter_ptick_edge.sv
// Rising-edge detector for the 25 MHz pixel tick, sampled in the 100 MHz domain.
module ptick_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic p_tick,
    output logic pix_rise
);
    logic p_tick_q;
    logic armed;

    // armed stays low for the first cycle after reset so a tick that is already high does not look like an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_tick_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            p_tick_q <= p_tick;
            armed    <= 1'b1;
        end
    end

    assign pix_rise = p_tick & ~p_tick_q & armed;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between the display scan-out and host writes.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_W  = vga_pkg::FB_W,
    parameter int FB_H  = vga_pkg::FB_H,
    parameter int PIX_W = vga_pkg::PIX_W
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              p_tick,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [PIX_W-1:0]  host_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  rgb,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [7:0]        drop_cnt,
    output logic              ovr_err
);
    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_W * FB_H);

    state_t            state;
    state_t            state_nxt;
    logic              pix_rise;
    logic              cap_von;
    logic              cap_hs;
    logic              cap_vs;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_slot;
    logic              accept;
    logic              in_range;
    logic              unused_bits;

    assign unused_bits = x[0] ^ y[0];

    // Row times FB_W as a sum of shifted rows, one term per set bit of FB_W (256+64 for 320).
    function automatic logic [ADDR_W-1:0] pix_index(input logic [8:0] row, input logic [8:0] col);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(col);
        for (int b = 0; b < ADDR_W; b++) begin
            if (FB_W[b]) begin
                acc = acc + (ADDR_W'(row) << b);
            end
        end
        return acc;
    endfunction

    ptick_edge u_ptick_edge (
        .clk      (clk_100MHz),
        .reset_n  (reset_n),
        .p_tick   (p_tick),
        .pix_rise (pix_rise)
    );

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign disp_slot = (state == RD) && cap_von;
    assign in_range  = host_addr < FB_LIMIT;
    assign accept    = host_valid && host_ready;

    always_comb begin
        state_nxt  = state;
        host_ready = reset_n && !disp_slot;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = host_data;
        case (state)
            IDLE:    if (pix_rise) state_nxt = RD;
            RD:      state_nxt = LAT;
            LAT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The display read owns the RAM port; host_ready is already low in that cycle.
        if (disp_slot) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (accept && in_range) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = host_addr;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cap_von   <= 1'b0;
            cap_hs    <= 1'b0;
            cap_vs    <= 1'b0;
            disp_addr <= '0;
            ovr_err   <= 1'b0;
        end else begin
            if (pix_rise && state == IDLE) begin
                cap_von   <= video_on;
                cap_hs    <= hsync;
                cap_vs    <= vsync;
                disp_addr <= pix_index(y[9:1], x[9:1]);
            end
            if (pix_rise && state != IDLE) begin
                ovr_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb      <= '0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            // mem_rdata holds the word requested in RD during LAT
            if (state == LAT) begin
                rgb     <= cap_von ? mem_rdata : '0;
                hsync_o <= cap_hs;
                vsync_o <= cap_vs;
            end
            if (accept && !in_range && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end
endmodule
